// File: rtl/usb_tx_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_bus_sequencer_if
//  Purpose  : Producer-side write port, host read strobe, status flags and
//             bus-driver outputs of the USB TX bus sequencer, bundled as one
//             interface.
//  Revision : 1.0  initial release
// ============================================================================
interface usb_tx_bus_sequencer_if #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 5
);
    // Producer side
    logic [WIDTH-1:0]    in_data;
    logic                in_wr;
    logic                in_full;

    // Host handshake and status
    logic                usb_rd;
    logic                pkt_rdy;
    logic [DEPTH_LOG2:0] fill_level;
    logic                underrun;
    logic                overrun;
    logic                clear_status;

    // Bus driver side
    logic [WIDTH-1:0]    data;
    logic                enabledt;

    // Sequencer view
    modport slave (
        input  in_data, in_wr, usb_rd, clear_status,
        output in_full, pkt_rdy, fill_level, underrun, overrun, data, enabledt
    );

    // Producer / host view
    modport master (
        output in_data, in_wr, usb_rd, clear_status,
        input  in_full, pkt_rdy, fill_level, underrun, overrun, data, enabledt
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_bus_sequencer
//  Purpose  : FIFO-buffers producer words and, on a host read strobe,
//             sequences one PKT_WORDS packet onto the shared USB data bus
//             through the tristate driver, with one-cycle turn-on/turn-off.
//  Revision : 1.0  initial release
// ============================================================================
module usb_tx_bus_sequencer #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 5,
    parameter int PKT_WORDS  = 16
) (
    input  logic                   usbclk,
    input  logic                   reset,
    usb_tx_bus_sequencer_if.slave  bus
);

    localparam int                  c_DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_PKT_CNT   = (DEPTH_LOG2 + 1)'(PKT_WORDS);
    localparam logic [DEPTH_LOG2:0] c_LAST_IDX  = (DEPTH_LOG2 + 1)'(PKT_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TURN_ON  = 2'd1,
        S_DRIVE    = 2'd2,
        S_TURN_OFF = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WIDTH-1:0]      r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   r_word_cnt;

    logic [WIDTH-1:0]      r_data;
    logic                  r_enabledt;
    logic                  r_underrun;
    logic                  r_overrun;

    logic                  w_full;
    logic                  w_pkt_rdy;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start;
    logic                  w_last_pop;
    logic                  w_set_underrun;
    logic                  w_set_overrun;

    // Occupancy-derived status is purely combinational from the count
    assign w_full        = (r_count == c_DEPTH_CNT);
    assign w_pkt_rdy     = (r_count >= c_PKT_CNT);
    assign w_push        = bus.in_wr && !w_full;
    assign w_set_overrun = bus.in_wr && w_full;
    assign w_rd_ptr_nxt  = r_rd_ptr + 1'b1;

    // State register
    always_ff @(posedge usbclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode; usb_rd is ignored in the
    // turn-on/turn-off phases so the host cannot pop or flag an underrun there
    always_comb begin
        w_state_nxt    = r_state;
        w_start        = 1'b0;
        w_pop          = 1'b0;
        w_last_pop     = 1'b0;
        w_set_underrun = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.usb_rd) begin
                    if (w_pkt_rdy) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_TURN_ON;
                    end else begin
                        w_set_underrun = 1'b1;
                    end
                end
            end
            S_TURN_ON: begin
                w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                if (bus.usb_rd) begin
                    w_pop = 1'b1;
                    if (r_word_cnt == c_LAST_IDX) begin
                        w_last_pop  = 1'b1;
                        w_state_nxt = S_TURN_OFF;
                    end
                end
            end
            S_TURN_OFF: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are not reset, only the pointers are
    always_ff @(posedge usbclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap naturally at 2**DEPTH_LOG2
    always_ff @(posedge usbclk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Position within the current burst
    always_ff @(posedge usbclk) begin
        if (reset) begin
            r_word_cnt <= '0;
        end else if (w_start) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    // Bus driver data/enable: word 0 is presented on entry to turn-on, each
    // pop presents the following word, and the last pop keeps the final word
    // on data while the enable is withdrawn
    always_ff @(posedge usbclk) begin
        if (reset) begin
            r_data     <= '0;
            r_enabledt <= 1'b0;
        end else if (w_start) begin
            r_data     <= r_mem[r_rd_ptr];
            r_enabledt <= 1'b1;
        end else if (w_last_pop) begin
            r_enabledt <= 1'b0;
        end else if (w_pop) begin
            r_data     <= r_mem[w_rd_ptr_nxt];
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge usbclk) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= w_set_underrun | (r_underrun & ~bus.clear_status);
            r_overrun  <= w_set_overrun  | (r_overrun  & ~bus.clear_status);
        end
    end

    assign bus.in_full    = w_full;
    assign bus.pkt_rdy    = w_pkt_rdy;
    assign bus.fill_level = r_count;
    assign bus.data       = r_data;
    assign bus.enabledt   = r_enabledt;
    assign bus.underrun   = r_underrun;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_tx_bus_sequencer
//  Purpose  : Directed self-checking bench for usb_tx_bus_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_tx_bus_sequencer;

    localparam int c_PKT = 16;

    logic usbclk = 1'b0;
    logic reset  = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    logic [15:0] exp_q [$];

    usb_tx_bus_sequencer_if #(.WIDTH(16), .DEPTH_LOG2(5)) bus_if ();

    usb_tx_bus_sequencer #(
        .WIDTH      (16),
        .DEPTH_LOG2 (5),
        .PKT_WORDS  (c_PKT)
    ) dut (
        .usbclk (usbclk),
        .reset  (reset),
        .bus    (bus_if.slave)
    );

    always #5 usbclk = ~usbclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge usbclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_word(input logic [15:0] v);
        bus_if.in_wr   = 1'b1;
        bus_if.in_data = v;
        tick();
        bus_if.in_wr   = 1'b0;
        if (exp_q.size() < 32) exp_q.push_back(v);
    endtask

    // One full burst checked against the model queue; optional stall after
    // word stall_at and optional concurrent writes starting at wr_base
    task automatic run_burst(input int stall_at, input int stall_len,
                             input bit wr_during, input logic [15:0] wr_base);
        logic [15:0] w [c_PKT];
        int          fill0;
        int          wr_n;
        if (exp_q.size() < c_PKT) begin
            chk("burst_avail", exp_q.size(), c_PKT);
            return;
        end
        for (int i = 0; i < c_PKT; i++) w[i] = exp_q[i];
        fill0 = exp_q.size();
        wr_n  = 0;
        bus_if.usb_rd = 1'b1;
        tick();
        chk("on_en", bus_if.enabledt, 1);
        chk("on_data", bus_if.data, w[0]);
        tick();
        chk("turnon_en", bus_if.enabledt, 1);
        chk("turnon_data", bus_if.data, w[0]);
        if (wr_during) begin
            bus_if.in_wr   = 1'b1;
            bus_if.in_data = wr_base;
        end
        for (int i = 1; i < c_PKT; i++) begin
            tick();
            if (wr_during) begin
                exp_q.push_back(16'(wr_base + wr_n));
                wr_n++;
                bus_if.in_data = 16'(wr_base + wr_n);
                chk("pushpop_fill", bus_if.fill_level, fill0);
            end
            chk("drive_data", bus_if.data, w[i]);
            chk("drive_en", bus_if.enabledt, 1);
            if (i == stall_at) begin
                bus_if.usb_rd = 1'b0;
                bus_if.in_wr  = 1'b0;
                repeat (stall_len) begin
                    tick();
                    chk("stall_data", bus_if.data, w[i]);
                    chk("stall_en", bus_if.enabledt, 1);
                end
                bus_if.usb_rd = 1'b1;
                bus_if.in_wr  = wr_during;
            end
        end
        tick();
        if (wr_during) exp_q.push_back(16'(wr_base + wr_n));
        bus_if.in_wr  = 1'b0;
        bus_if.usb_rd = 1'b0;
        chk("off_en", bus_if.enabledt, 0);
        chk("off_data", bus_if.data, w[c_PKT-1]);
        chk("off_fill", bus_if.fill_level, wr_during ? fill0 : fill0 - c_PKT);
        repeat (c_PKT) void'(exp_q.pop_front());
        tick();
        chk("gap_en", bus_if.enabledt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.in_data      = '0;
        bus_if.in_wr        = 1'b0;
        bus_if.usb_rd       = 1'b0;
        bus_if.clear_status = 1'b0;
        tick();

        // 1: reset state, then a plain 16-word burst
        do_reset();
        chk("rst_en", bus_if.enabledt, 0);
        chk("rst_data", bus_if.data, 0);
        chk("rst_fill", bus_if.fill_level, 0);
        chk("rst_full", bus_if.in_full, 0);
        chk("rst_rdy", bus_if.pkt_rdy, 0);
        chk("rst_flags", {bus_if.underrun, bus_if.overrun}, 0);
        for (int i = 0; i < 16; i++) write_word(16'(16'h1000 + i));
        chk("t1_fill", bus_if.fill_level, 16);
        chk("t1_rdy", bus_if.pkt_rdy, 1);
        run_burst(-1, 0, 1'b0, 16'h0);
        chk("t1_empty", bus_if.fill_level, 0);

        // 2: underrun with 15 words, then packet ready, then clear
        do_reset();
        for (int i = 0; i < 15; i++) write_word(16'(16'h2000 + i));
        chk("t2_rdy15", bus_if.pkt_rdy, 0);
        bus_if.usb_rd = 1'b1;
        tick();
        bus_if.usb_rd = 1'b0;
        chk("t2_underrun", bus_if.underrun, 1);
        chk("t2_en", bus_if.enabledt, 0);
        tick();
        chk("t2_en_hold", bus_if.enabledt, 0);
        write_word(16'h200F);
        chk("t2_rdy16", bus_if.pkt_rdy, 1);
        bus_if.clear_status = 1'b1;
        tick();
        bus_if.clear_status = 1'b0;
        chk("t2_clear", bus_if.underrun, 0);

        // 3: stalled burst
        do_reset();
        for (int i = 0; i < 16; i++) write_word(16'(16'h1000 + i));
        run_burst(5, 3, 1'b0, 16'h0);

        // 4: overfill from a non-zero pointer, overrun, wrap-around read
        for (int i = 0; i < 33; i++) begin
            write_word(16'(16'h4000 + i));
            if (i == 31) begin
                chk("t4_full", bus_if.in_full, 1);
                chk("t4_ovr_pre", bus_if.overrun, 0);
            end
        end
        chk("t4_overrun", bus_if.overrun, 1);
        chk("t4_fill", bus_if.fill_level, 32);
        run_burst(-1, 0, 1'b0, 16'h0);
        chk("t4_notfull", bus_if.in_full, 0);
        run_burst(-1, 0, 1'b0, 16'h0);
        chk("t4_empty", bus_if.fill_level, 0);
        bus_if.clear_status = 1'b1;
        tick();
        bus_if.clear_status = 1'b0;
        chk("t4_clear", bus_if.overrun, 0);

        // 5: writes concurrent with a burst, then a back-to-back burst
        for (int i = 0; i < 16; i++) write_word(16'(16'h5000 + i));
        run_burst(-1, 0, 1'b1, 16'h5100);
        chk("t5_rdy2", bus_if.pkt_rdy, 1);
        run_burst(-1, 0, 1'b0, 16'h0);
        chk("t5_empty", bus_if.fill_level, 0);

        // 6: reset mid-burst, then underrun with clear pending (set wins)
        for (int i = 0; i < 16; i++) write_word(16'(16'h6000 + i));
        bus_if.usb_rd = 1'b1;
        tick();
        tick();
        repeat (7) tick();
        chk("t6_word7", bus_if.data, 16'h6007);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.usb_rd = 1'b0;
        exp_q.delete();
        chk("t6_en", bus_if.enabledt, 0);
        chk("t6_data", bus_if.data, 0);
        chk("t6_fill", bus_if.fill_level, 0);
        bus_if.usb_rd       = 1'b1;
        bus_if.clear_status = 1'b1;
        tick();
        bus_if.usb_rd       = 1'b0;
        bus_if.clear_status = 1'b0;
        chk("t6_underrun", bus_if.underrun, 1);
        chk("t6_en_idle", bus_if.enabledt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
